aer_spike_encoder: RTL and testbench
====================================

Name: aer_spike_encoder

Overview:
- Upstream neighbour of the picture-number detection stage.
- Latches one timestep's spike bitmap for a group of pixels and serialises each set bit, lowest first, as an AER index (base offset + bit position).
- Output is a valid/ready stream. The downstream stage drives aer_ready high only while it is idle and can accept AER_index.
- Reports end of frame and the number of events emitted.

Parameters:
- NUM_NEURON, 64, width of the spike bitmap accepted per frame.
- IDX_W, 16, AER index width; matches the 16-bit AER_index bus downstream.
- CNT_W, $clog2(NUM_NEURON+1), event counter width.
- MAX_EVENTS, 32, per-frame event cap; used only with AER_EVENT_LIMIT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- spike_in_vec  in  NUM_NEURON  spike bitmap; bit i = pixel i fired
- spike_in_base  in  IDX_W  index offset added to every bit position in this frame
- spike_in_valid  in  1  bitmap/base valid
- spike_in_ready  out  1  encoder can accept a frame
- aer_index  out  IDX_W  emitted event index
- aer_valid  out  1  event valid
- aer_ready  in  1  downstream accepts event
- frame_done  out  1  one-cycle pulse, frame fully emitted
- frame_event_cnt  out  CNT_W  events emitted in last frame; held until next frame_done
- frame_overflow  out  1  events dropped in last frame; constant 0 without AER_EVENT_LIMIT_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. All state is async-cleared.
- Reset values:
  - state = IDLE
  - spike_in_ready = 0, then 1 in the first cycle after rst deasserts (registered from IDLE)
  - aer_valid = 0, aer_index = 0
  - frame_done = 0, frame_event_cnt = 0, frame_overflow = 0
  - pending mask = 0, base = 0, running count = 0
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - spike_in_ready = 1.
  - On spike_in_valid & spike_in_ready: latch pending <= spike_in_vec and base <= spike_in_base; clear running count; go to SCAN.
- SCAN:
  - spike_in_ready = 0.
  - If pending == 0, go to DONE.
  - Otherwise take p = lowest set bit of pending. Register aer_index <= base + p, computed modulo 2^IDX_W; wrap-around is legal and silent. Set aer_valid <= 1 and go to EMIT.
- EMIT:
  - Hold aer_index and aer_valid stable until aer_ready.
  - On aer_valid & aer_ready: clear bit p in pending, count += 1, aer_valid <= 0, go to SCAN.
  - aer_ready while aer_valid = 0 has no effect.
- DONE:
  - frame_done = 1 for exactly one cycle.
  - frame_event_cnt <= count.
  - Go to IDLE.
- Latency:
  - Frame accept in cycle t gives the first aer_valid at t+2.
  - A handshake in cycle t gives the next aer_valid at t+2.
  - After the final handshake at t: SCAN at t+1, frame_done at t+2, spike_in_ready back at t+3.
- Empty bitmap: no events; frame_done 2 cycles after accept with frame_event_cnt = 0.
- spike_in_valid while busy is ignored, since ready is low; the upstream must hold its data.
- All-ones bitmap: NUM_NEURON events, indices base .. base+NUM_NEURON-1 in ascending order.
- A reset mid-frame discards pending events. It does not emit frame_done.

Optional Feature:
- Macro: AER_EVENT_LIMIT_EN.
- Defined:
  - In SCAN, when count == MAX_EVENTS and pending != 0, set frame_overflow <= 1 and go to DONE; remaining bits are dropped.
  - frame_overflow is cleared on the next frame accept.
- Undefined:
  - No cap; every set bit is emitted.
  - frame_overflow tied to 0.

Decomposition:
- Shared package/defines holds:
  - the FSM state encodings (2-bit)
  - IDX_W default (16), shared with the picture-number stage
- One sub-module: aer_lsb_priority_enc.
  - Combinational; input NUM_NEURON-bit vector; outputs lowest set bit index and an any-set flag.
  - Used in SCAN.

Test Plan:
- Base 0, vec = 0x...0000_0025, aer_ready always 1 -> indices 0, 2, 5; each aer_valid 2 cycles after the previous handshake; frame_done with cnt = 3.
- Base 16, vec bit 63 only -> single index 79; cnt = 1.
- Vec = 0 -> no aer_valid; frame_done 2 cycles after accept; cnt = 0.
- aer_ready low for 10 cycles while aer_valid = 1, vec = 0x3 -> aer_index held at base+0 and stable throughout; then base+1 after release; spike_in_valid pulses during the frame are not accepted.
- Base 0xFFF0, all-ones vec -> 64 events: 0xFFF0..0xFFFF, then 0x0000..0x002F; cnt = 64.
- rst asserted while in EMIT -> aer_valid drops immediately (async); no frame_done; after release spike_in_ready = 1 and a new frame encodes correctly.
- With AER_EVENT_LIMIT_EN: MAX_EVENTS = 32 and all-ones vec -> 32 events (base..base+31); frame_overflow = 1; cnt = 32.

Source files
------------

// File: rtl/aer_spike_encoder_pkg.sv
// Shared definitions for the AER spike encoder: FSM state encoding and the
// AER index bus width shared with the picture-number detection stage.
package aer_spike_encoder_pkg;

    localparam int AER_IDX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } aer_state_e;

endpackage

// File: rtl/aer_spike_encoder_lsb_enc.sv
// aer_lsb_priority_enc: combinational lowest-set-bit finder over the pending
// spike mask; idx_o is only meaningful while any_o is high.
module aer_lsb_priority_enc #(
    parameter int N  = 64,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scanning downward lets the lowest set bit be the final assignment.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/aer_spike_encoder.sv
// Serialises one frame's spike bitmap into AER indices (base + bit position,
// lowest bit first). Optional per-frame event cap: define AER_EVENT_LIMIT_EN.
module aer_spike_encoder
    import aer_spike_encoder_pkg::*;
#(
    parameter int NUM_NEURON = 64,
    parameter int IDX_W      = AER_IDX_W,
    parameter int CNT_W      = $clog2(NUM_NEURON + 1),
    parameter int MAX_EVENTS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_NEURON-1:0] spike_in_vec,
    input  logic [IDX_W-1:0]      spike_in_base,
    input  logic                  spike_in_valid,
    output logic                  spike_in_ready,
    output logic [IDX_W-1:0]      aer_index,
    output logic                  aer_valid,
    input  logic                  aer_ready,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      frame_event_cnt,
    output logic                  frame_overflow
);

    localparam int PW = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;

`ifdef AER_EVENT_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    aer_state_e            state_q;
    logic [NUM_NEURON-1:0] pending_q;
    logic [IDX_W-1:0]      base_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [PW-1:0]         p_q;
    logic                  spike_in_ready_q;
    logic [IDX_W-1:0]      aer_index_q;
    logic                  aer_valid_q;
    logic                  frame_done_q;
    logic [CNT_W-1:0]      frame_event_cnt_q;
    logic                  frame_overflow_q;

    logic [PW-1:0]         lsb_idx;
    logic                  lsb_any;

    aer_lsb_priority_enc #(
        .N  (NUM_NEURON),
        .IW (PW)
    ) u_lsb_enc (
        .vec_i (pending_q),
        .idx_o (lsb_idx),
        .any_o (lsb_any)
    );

    // frame_done is raised on the SCAN->DONE edge so it is high exactly
    // during the DONE cycle, alongside the updated event count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            pending_q         <= '0;
            base_q            <= '0;
            cnt_q             <= '0;
            p_q               <= '0;
            spike_in_ready_q  <= 1'b0;
            aer_index_q       <= '0;
            aer_valid_q       <= 1'b0;
            frame_done_q      <= 1'b0;
            frame_event_cnt_q <= '0;
            frame_overflow_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    spike_in_ready_q <= 1'b1;
                    if (spike_in_valid && spike_in_ready_q) begin
                        pending_q        <= spike_in_vec;
                        base_q           <= spike_in_base;
                        cnt_q            <= '0;
                        frame_overflow_q <= 1'b0;
                        spike_in_ready_q <= 1'b0;
                        state_q          <= SCAN;
                    end
                end
                SCAN: begin
                    if (!lsb_any) begin
                        frame_done_q      <= 1'b1;
                        frame_event_cnt_q <= cnt_q;
                        state_q           <= DONE;
                    end else if (LIMIT_EN && (cnt_q == CNT_W'(MAX_EVENTS))) begin
                        frame_overflow_q  <= 1'b1;
                        frame_done_q      <= 1'b1;
                        frame_event_cnt_q <= cnt_q;
                        state_q           <= DONE;
                    end else begin
                        p_q         <= lsb_idx;
                        aer_index_q <= base_q + IDX_W'(lsb_idx);
                        aer_valid_q <= 1'b1;
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    if (aer_ready) begin
                        pending_q[p_q] <= 1'b0;
                        cnt_q          <= cnt_q + 1'b1;
                        aer_valid_q    <= 1'b0;
                        state_q        <= SCAN;
                    end
                end
                DONE: begin
                    spike_in_ready_q <= 1'b1;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spike_in_ready  = spike_in_ready_q;
    assign aer_index       = aer_index_q;
    assign aer_valid       = aer_valid_q;
    assign frame_done      = frame_done_q;
    assign frame_event_cnt = frame_event_cnt_q;
    assign frame_overflow  = LIMIT_EN ? frame_overflow_q : 1'b0;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Bench for aer_spike_encoder: directed and random frames checked against an
// expected-index queue built from the bitmap; honours AER_EVENT_LIMIT_EN.
module tb_aer_spike_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] spike_in_vec;
    logic [15:0] spike_in_base;
    logic        spike_in_valid;
    logic        spike_in_ready;
    logic [15:0] aer_index;
    logic        aer_valid;
    logic        aer_ready;
    logic        frame_done;
    logic [6:0]  frame_event_cnt;
    logic        frame_overflow;

    int vecs = 0;
    int errs = 0;

    aer_spike_encoder dut (
        .clk             (clk),
        .rst             (rst),
        .spike_in_vec    (spike_in_vec),
        .spike_in_base   (spike_in_base),
        .spike_in_valid  (spike_in_valid),
        .spike_in_ready  (spike_in_ready),
        .aer_index       (aer_index),
        .aer_valid       (aer_valid),
        .aer_ready       (aer_ready),
        .frame_done      (frame_done),
        .frame_event_cnt (frame_event_cnt),
        .frame_overflow  (frame_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers one frame, then walks it cycle by cycle at negedges. n counts
    // cycles since the last accept or handshake edge.
    task automatic run_frame(input logic [63:0] vec, input logic [15:0] base,
                             input int rdy_pct, input int stall_cycles);
        logic [15:0] exp_q[$];
        int  n_ev;
        bit  exp_ovf;
        int  n;
        int  guard;
        int  stall;
        bit  done;
        exp_q   = {};
        exp_ovf = 1'b0;
        stall   = stall_cycles;
        for (int i = 0; i < 64; i++) begin
            if (vec[i]) begin
`ifdef AER_EVENT_LIMIT_EN
                if (exp_q.size() == 32) begin
                    exp_ovf = 1'b1;
                    break;
                end
`endif
                exp_q.push_back(16'(int'(base) + i));
            end
        end
        n_ev = exp_q.size();

        guard = 0;
        @(negedge clk);
        while (!spike_in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_frame", 64'(spike_in_ready), 64'd1);
        spike_in_vec   = vec;
        spike_in_base  = base;
        spike_in_valid = 1'b1;
        aer_ready      = 1'b0;
        @(negedge clk);
        spike_in_valid = 1'b0;
        spike_in_vec   = {$urandom, $urandom};
        n     = 1;
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 3000) begin
            check("busy_ready_low", 64'(spike_in_ready), 64'd0);
            if (n == 1) begin
                check("gap1_valid_low", 64'(aer_valid), 64'd0);
                check("gap1_done_low", 64'(frame_done), 64'd0);
            end else if (n == 2) begin
                if (exp_q.size() > 0) begin
                    check("valid_at_gap2", 64'(aer_valid), 64'd1);
                end else begin
                    check("extra_event", 64'(aer_valid), 64'd0);
                    check("done_at_gap2", 64'(frame_done), 64'd1);
                    check("event_cnt", 64'(frame_event_cnt), 64'(n_ev));
                    check("overflow", 64'(frame_overflow), 64'(exp_ovf));
                    done = 1'b1;
                end
            end else begin
                check("valid_held", 64'(aer_valid), 64'd1);
            end
            if (aer_valid && exp_q.size() > 0) begin
                check("aer_index", 64'(aer_index), 64'(exp_q[0]));
            end
            spike_in_valid = 1'b0;
            aer_ready      = 1'b0;
            if (aer_valid) begin
                if (stall > 0) begin
                    stall--;
                    spike_in_valid = 1'b1;
                    spike_in_vec   = {$urandom, $urandom};
                    spike_in_base  = 16'($urandom);
                end else begin
                    aer_ready = (int'($urandom_range(99)) < rdy_pct);
                end
                if (aer_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    n = 0;
                end
            end else begin
                aer_ready = 1'($urandom_range(1));
            end
            @(negedge clk);
            n++;
            guard++;
        end
        aer_ready = 1'b0;
        if (!done) begin
            check("frame_timeout", 64'd0, 64'd1);
        end else begin
            check("done_one_cycle", 64'(frame_done), 64'd0);
            check("ready_after_done", 64'(spike_in_ready), 64'd1);
            check("event_cnt_held", 64'(frame_event_cnt), 64'(n_ev));
        end
    endtask

    initial begin
        int guard;
        rst            = 1'b1;
        spike_in_vec   = '0;
        spike_in_base  = '0;
        spike_in_valid = 1'b0;
        aer_ready      = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(spike_in_ready), 64'd0);
        check("rst_valid", 64'(aer_valid), 64'd0);
        check("rst_index", 64'(aer_index), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_cnt", 64'(frame_event_cnt), 64'd0);
        check("rst_ovf", 64'(frame_overflow), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(spike_in_ready), 64'd1);

        run_frame(64'h25, 16'h0000, 100, 0);
        run_frame(64'h8000_0000_0000_0000, 16'd16, 100, 0);
        run_frame(64'h0, 16'h1234, 100, 0);
        run_frame(64'h3, 16'h0040, 100, 10);
        run_frame({64{1'b1}}, 16'hFFF0, 100, 0);

        // Reset while an event is waiting in EMIT.
        @(negedge clk);
        spike_in_vec   = {64{1'b1}};
        spike_in_base  = 16'h0100;
        spike_in_valid = 1'b1;
        @(negedge clk);
        spike_in_valid = 1'b0;
        guard = 0;
        while (!aer_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("pre_rst_valid", 64'(aer_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("async_valid_drop", 64'(aer_valid), 64'd0);
        check("async_index_clr", 64'(aer_index), 64'd0);
        check("async_ready_clr", 64'(spike_in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_in_rst", 64'(frame_done), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst2", 64'(spike_in_ready), 64'd1);
        check("no_done_after_rst", 64'(frame_done), 64'd0);
        run_frame(64'h0000_0000_0000_0912, 16'h0200, 100, 0);

        for (int f = 0; f < 12; f++) begin
            logic [63:0] v;
            v = {$urandom, $urandom};
            if (f % 3 == 1) v = v & {$urandom, $urandom} & {$urandom, $urandom};
            if (f % 4 == 3) v = {64{1'b1}};
            run_frame(v, 16'($urandom), 30 + int'($urandom_range(70)), int'($urandom_range(3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
